// File: rtl/phy_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
// Shared constants for the PHY transmit path.
//   WIDTH     : byte width carried by the lane mux and serializer
//   IDLE_BYTE : idle/comma byte sent whenever no data byte is buffered
//   FRAME_LEN : serial clocks per transmitted byte
// -----------------------------------------------------------------------------
package phy_pkg;

    localparam int         WIDTH     = 8;
    localparam logic [7:0] IDLE_BYTE = 8'hBC;
    localparam int         FRAME_LEN = WIDTH;

endpackage

// File: rtl/par_serial_fifo.sv
// -----------------------------------------------------------------------------
// par_serial_fifo
// Small synchronous FIFO that decouples the byte-lane mux from the serializer.
// Ports:
//   clk_32f  : bit clock
//   reset    : asynchronous active-high reset, empties the buffer
//   i_data   : byte to write
//   i_push   : write request (ignored while full)
//   i_pop    : read request (ignored while empty)
//   o_data   : head entry, valid whenever o_empty is low
//   o_full   : occupancy == DEPTH
//   o_empty  : occupancy == 0
// -----------------------------------------------------------------------------
module par_serial_fifo
    import phy_pkg::*;
#(
    parameter int WIDTH = phy_pkg::WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_push,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an empty count makes stale entries unreachable.
    always_ff @(posedge clk_32f) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/par_serial_tx.sv
// -----------------------------------------------------------------------------
// par_serial_tx
// Parallel-to-serial transmit stage. Bytes from the upstream mux are buffered
// and shifted out MSB-first, one bit per clock, in back-to-back WIDTH-bit
// frames. An empty buffer at a frame boundary sends IDLE_BYTE instead.
// Ports:
//   clk_32f     : bit clock, rising edge
//   reset       : asynchronous active-high reset
//   data_in     : byte from the upstream mux
//   valid_in    : data_in valid; accepted on an edge where ready_out is high
//   ready_out   : buffer not full (combinational from occupancy)
//   serial_out  : serial bit, MSB of the shift register
//   frame_start : high during the MSB of every frame
//   data_flag   : high for the whole frame when it carries a buffered byte
// -----------------------------------------------------------------------------
module par_serial_tx
    import phy_pkg::*;
#(
    parameter int               WIDTH     = phy_pkg::WIDTH,
    parameter logic [WIDTH-1:0] IDLE_BYTE = WIDTH'(phy_pkg::IDLE_BYTE),
    parameter int               DEPTH     = 2
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             frame_start,
    output logic             data_flag
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_start;
    logic             r_data_flag;

    logic             w_load;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;

    // Reset leaves the counter at LAST_BIT so the first edge after release
    // is a load edge.
    assign w_load = (r_bit_cnt == LAST_BIT);
    assign w_push = valid_in && !w_full;
    // Pop is decided from pre-edge occupancy, so a byte pushed on a load edge
    // into an empty buffer is not bypassed; it waits for the next frame.
    assign w_pop  = w_load && !w_empty;

    par_serial_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_32f (clk_32f),
        .reset   (reset),
        .i_data  (data_in),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_bit_cnt     <= LAST_BIT;
            r_shift       <= '0;
            r_frame_start <= 1'b0;
            r_data_flag   <= 1'b0;
        end else if (w_load) begin
            r_shift       <= w_empty ? IDLE_BYTE : w_head;
            r_data_flag   <= !w_empty;
            r_bit_cnt     <= '0;
            r_frame_start <= 1'b1;
        end else begin
            r_shift       <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt     <= r_bit_cnt + 1'b1;
            r_frame_start <= 1'b0;
        end
    end

    // ready_out falls while full; a pop on that edge reopens it next cycle.
    assign ready_out   = !w_full;
    assign serial_out  = r_shift[WIDTH-1];
    assign frame_start = r_frame_start;
    assign data_flag   = r_data_flag;

endmodule

// File: tb/tb_par_serial_tx.sv
module tb_par_serial_tx;

    localparam int W     = 8;
    localparam int DEPTH = 2;
    localparam logic [7:0] IDLE = 8'hBC;

    logic         clk_32f = 1'b0;
    logic         reset;
    logic [W-1:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic         serial_out;
    logic         frame_start;
    logic         data_flag;

    par_serial_tx #(.WIDTH(W), .IDLE_BYTE(IDLE), .DEPTH(DEPTH)) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .serial_out  (serial_out),
        .frame_start (frame_start),
        .data_flag   (data_flag)
    );

    always #5 clk_32f = ~clk_32f;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model state
    int         m_cnt;
    logic [7:0] m_shift;
    logic       m_fs;
    logic       m_df;
    logic [7:0] m_q[$];

    // scoreboard of accepted bytes and frame assembler on DUT outputs
    logic [7:0] sb_q[$];
    logic       last_acc;
    int         starts, frames_done, gap, nbits;
    logic       have_prev, collecting, col_flag, last_flag;
    logic [7:0] col, last_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = W - 1;
        m_shift = '0;
        m_fs    = 1'b0;
        m_df    = 1'b0;
        m_q.delete();
        sb_q.delete();
        have_prev   = 1'b0;
        collecting  = 1'b0;
        frames_done = starts;
        gap         = 0;
    endtask

    task automatic tick();
        logic push;
        logic [7:0] d;
        push = valid_in && (m_q.size() < DEPTH);
        d    = data_in;
        @(posedge clk_32f);
        if (m_cnt == W - 1) begin
            if (m_q.size() > 0) begin
                m_shift = m_q.pop_front();
                m_df    = 1'b1;
            end else begin
                m_shift = IDLE;
                m_df    = 1'b0;
            end
            m_cnt = 0;
            m_fs  = 1'b1;
        end else begin
            m_shift = {m_shift[6:0], 1'b0};
            m_cnt++;
            m_fs = 1'b0;
        end
        if (push) begin
            m_q.push_back(d);
            sb_q.push_back(d);
        end
        last_acc = push;
        #1;
        chk("serial_out", serial_out, m_shift[7]);
        chk("frame_start", frame_start, m_fs);
        chk("data_flag", data_flag, m_df);
        chk("ready_out", ready_out, (m_q.size() < DEPTH));
        // frame assembler on DUT outputs
        gap++;
        if (frame_start === 1'b1) begin
            if (have_prev) chk("fs_period", gap, phy_pkg::FRAME_LEN);
            have_prev  = 1'b1;
            gap        = 0;
            starts++;
            col        = {7'd0, serial_out};
            nbits      = 1;
            col_flag   = data_flag;
            collecting = 1'b1;
        end else if (collecting) begin
            col = {col[6:0], serial_out};
            nbits++;
            chk("df_hold", data_flag, col_flag);
        end
        if (collecting && nbits == W) begin
            frames_done++;
            last_byte  = col;
            last_flag  = col_flag;
            collecting = 1'b0;
            if (col_flag) begin
                if (sb_q.size() > 0) chk("sb_byte", col, sb_q.pop_front());
                else chk("sb_nonempty", sb_q.size(), 1);
            end
        end
    endtask

    // Wait for the first frame whose start is counted beyond s0 to complete.
    task automatic next_frame(input int s0, output logic [7:0] b, output logic f);
        int n = 0;
        while (!(starts > s0 && frames_done == starts) && n < 40) begin
            tick();
            n++;
        end
        chk("frame_wait", (n < 40), 1);
        b = last_byte;
        f = last_flag;
    endtask

    task automatic expect_frame(input string tag, input int s0, input logic [7:0] eb, input logic ef);
        logic [7:0] b;
        logic f;
        next_frame(s0, b, f);
        chk({tag, "_byte"}, b, eb);
        chk({tag, "_flag"}, f, ef);
    endtask

    initial begin
        int n;
        int s0;
        starts = 0;
        frames_done = 0;
        last_acc = 1'b0;
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        model_reset();
        #2;
        chk("rst_serial", serial_out, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_df", data_flag, 0);
        chk("rst_ready", ready_out, 1);
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1 reset = 1'b0;

        // idle stream: four comma frames
        for (int i = 0; i < 4; i++) expect_frame("idle", starts, IDLE, 1'b0);

        // single push just before a load edge
        n = 0;
        while (m_cnt != W - 2 && n < 20) begin tick(); n++; end
        data_in = 8'hA5; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        expect_frame("a5", starts, 8'hA5, 1'b1);
        expect_frame("a5_after", starts, IDLE, 1'b0);

        // back-to-back 11,22,33 with backpressure
        n = 0;
        while (m_cnt != 0 && n < 20) begin tick(); n++; end
        data_in = 8'h11; valid_in = 1'b1;
        chk("t3_ready_empty", ready_out, 1);
        tick();
        data_in = 8'h22;
        tick();
        chk("t3_full", ready_out, 0);
        data_in = 8'h33;
        n = 0;
        while (ready_out !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t3_wait", n, 6);
        chk("t3_pop_fs", frame_start, 1);
        s0 = starts - 1;
        tick();
        chk("t3_acc33", last_acc, 1);
        valid_in = 1'b0;
        expect_frame("t3_11", s0, 8'h11, 1'b1);
        expect_frame("t3_22", starts, 8'h22, 1'b1);
        expect_frame("t3_33", starts, 8'h33, 1'b1);
        expect_frame("t3_idle", starts, IDLE, 1'b0);

        // push on a load edge into an empty buffer: no bypass
        n = 0;
        while (!(m_cnt == W - 1 && m_q.size() == 0) && n < 20) begin tick(); n++; end
        data_in = 8'h5A; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        expect_frame("nobyp_idle", starts - 1, IDLE, 1'b0);
        expect_frame("nobyp_5a", starts, 8'h5A, 1'b1);

        // reset mid-frame with one byte buffered
        n = 0;
        while (m_cnt != W - 2 && n < 20) begin tick(); n++; end
        data_in = 8'hF0; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        data_in = 8'h77; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n = 0;
        while (m_cnt != 4 && n < 20) begin tick(); n++; end
        chk("f0_bit3", serial_out, 0);
        chk("f0_ready", ready_out, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_serial", serial_out, 0);
        chk("mid_rst_fs", frame_start, 0);
        chk("mid_rst_df", data_flag, 0);
        chk("mid_rst_ready", ready_out, 1);
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) expect_frame("post_rst", starts, IDLE, 1'b0);

        // random traffic, upstream holds data until accepted
        for (int i = 0; i < 2000; i++) begin
            if (!valid_in || last_acc) begin
                valid_in = 1'($urandom_range(0, 1));
                data_in  = 8'($urandom);
            end
            tick();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
